// File: rtl/struct_types.sv
// Shared FPU types: FP32 operand layout, divider flags and divider state encoding.
package struct_types;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] mant;
  } float_point_num;

  localparam logic [31:0] FP_QNAN    = 32'h7FC0_0000;
  localparam logic [7:0]  FP_EXP_MAX = 8'hFF;
  localparam int          FP_BIAS    = 127;

  typedef struct packed {
    logic invalid;
    logic div_by_zero;
    logic overflow;
    logic underflow;
  } fp_flags_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DIV,
    S_NORM,
    S_SPEC,
    S_DONE
  } div_state_e;

endpackage

// File: rtl/fpu_div_core_if.sv
// Operand/result handshake bundle of the FP32 divider core.
interface fpu_div_core_if;
  import struct_types::*;

  logic           in_valid;
  logic           in_ready;
  float_point_num a;
  float_point_num b;
  logic           out_valid;
  logic           out_ready;
  float_point_num result;
  fp_flags_t      flags;

  // Producer of operands / consumer of results.
  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, result, flags
  );

  // The divider core itself.
  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, result, flags
  );

endinterface

// File: rtl/fp_round_norm.sv
// Combinational normalise, round-to-nearest-even and range check for an
// FP32 quotient/product whose raw significand q lies in (0.5, 2).
// q[QBITS-1] has weight 2^0; bits below guard and round fold into sticky.
module fp_round_norm
  import struct_types::*;
#(
  parameter int QBITS = 26
) (
  input  logic [QBITS-1:0]   q,
  input  logic               sticky,
  input  logic signed [9:0]  e,
  input  logic               s,
  output float_point_num     result,
  output fp_flags_t          flags
);

  // Selects the bits below the round position; zero when QBITS == 26.
  localparam logic [QBITS-1:0] EXTRA_MASK = (QBITS'(1) << (QBITS - 26)) - QBITS'(1);

  logic [QBITS-1:0]  qn;
  logic signed [9:0] en;
  logic signed [9:0] ef;
  logic [23:0]       sig;
  logic              guard;
  logic              rnd;
  logic              stk;
  logic              inc;
  logic [24:0]       sum;

  // Normalise to [1,2), round, renormalise on carry, then clamp the exponent range.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch can be inferred.
    qn = q;
    en = e;
    if (!q[QBITS-1]) begin
      qn = q << 1;
      en = e - 10'sd1;
    end
    sig   = qn[QBITS-1 -: 24];
    guard = qn[QBITS-25];
    rnd   = qn[QBITS-26];
    stk   = sticky | (|(qn & EXTRA_MASK));
    inc   = guard & (rnd | stk | sig[0]);
    sum   = {1'b0, sig} + {24'd0, inc};
    ef    = sum[24] ? (en + 10'sd1) : en;

    result = '{sign: s, exp: ef[7:0], mant: (sum[24] ? sum[23:1] : sum[22:0])};
    flags  = '0;
    if (ef >= 10'sd255) begin
      result         = '{sign: s, exp: FP_EXP_MAX, mant: 23'd0};
      flags.overflow = 1'b1;
    end else if (ef <= 10'sd0) begin
      result          = '{sign: s, exp: 8'd0, mant: 23'd0};
      flags.underflow = 1'b1;
    end
  end

endmodule

// File: rtl/fpu_div_core.sv
// Iterative FP32 divider: radix-2 restoring significand division, one
// operation in flight, valid/ready on both sides. QBITS must be >= 26.
module fpu_div_core
  import struct_types::*;
#(
  parameter int QBITS = 26
) (
  input logic           clk,
  input logic           rst,
  fpu_div_core_if.slave bus
);

  localparam int CW = $clog2(QBITS);

  div_state_e        state_q;
  div_state_e        state_d;

  logic [CW-1:0]     cnt_q;
  logic signed [9:0] e_q;
  logic              s_q;
  logic [23:0]       mb_q;
  logic [25:0]       rem_q;
  logic [QBITS-1:0]  q_q;
  float_point_num    spec_res_q;
  fp_flags_t         spec_flags_q;
  float_point_num    result_q;
  fp_flags_t         flags_q;

  logic              a_zero, a_nan, a_inf;
  logic              b_zero, b_nan, b_inf;
  logic              sgn;
  logic              is_special;
  float_point_num    spec_res;
  fp_flags_t         spec_flags;
  logic signed [9:0] e_init;

  logic [26:0]       diff;
  logic              qbit;
  logic [25:0]       rem_keep;

  float_point_num    rn_result;
  fp_flags_t         rn_flags;

  // Classify the presented operands and resolve the special cases in priority order.
  always_comb begin
    a_zero     = (bus.a.exp == 8'd0);
    b_zero     = (bus.b.exp == 8'd0);
    a_nan      = (bus.a.exp == FP_EXP_MAX) && (bus.a.mant != 23'd0);
    b_nan      = (bus.b.exp == FP_EXP_MAX) && (bus.b.mant != 23'd0);
    a_inf      = (bus.a.exp == FP_EXP_MAX) && (bus.a.mant == 23'd0);
    b_inf      = (bus.b.exp == FP_EXP_MAX) && (bus.b.mant == 23'd0);
    sgn        = bus.a.sign ^ bus.b.sign;
    is_special = 1'b1;
    spec_res   = '0;
    spec_flags = '0;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_res           = float_point_num'(FP_QNAN);
      spec_flags.invalid = 1'b1;
    end else if (b_zero && !a_inf) begin
      spec_res               = '{sign: sgn, exp: FP_EXP_MAX, mant: 23'd0};
      spec_flags.div_by_zero = 1'b1;
    end else if (a_inf) begin
      spec_res = '{sign: sgn, exp: FP_EXP_MAX, mant: 23'd0};
    end else if (b_inf || a_zero) begin
      spec_res = '{sign: sgn, exp: 8'd0, mant: 23'd0};
    end else begin
      is_special = 1'b0;
    end
  end

  // Biased quotient exponent before normalisation.
  assign e_init = $signed({2'b00, bus.a.exp}) - $signed({2'b00, bus.b.exp}) + 10'(FP_BIAS);

  // One restoring step: subtract the divisor if it fits, then shift the remainder.
  always_comb begin
    diff     = {1'b0, rem_q} - {3'b000, mb_q};
    qbit     = ~diff[26];
    rem_keep = qbit ? diff[25:0] : rem_q;
  end

  fp_round_norm #(.QBITS(QBITS)) u_round_norm (
    .q      (q_q),
    .sticky (rem_q != 26'd0),
    .e      (e_q),
    .s      (s_q),
    .result (rn_result),
    .flags  (rn_flags)
  );

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (bus.in_valid) state_d = is_special ? S_SPEC : S_DIV;
      S_DIV:  if (cnt_q == CW'(QBITS - 1)) state_d = S_NORM;
      S_NORM: state_d = S_DONE;
      S_SPEC: state_d = S_DONE;
      S_DONE: if (bus.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs; flags are only presented alongside a valid result.
  always_comb begin
    bus.in_ready  = (state_q == S_IDLE);
    bus.out_valid = (state_q == S_DONE);
    bus.result    = result_q;
    bus.flags     = (state_q == S_DONE) ? flags_q : fp_flags_t'('0);
  end

  // Operand capture and iteration; the result register only changes on entry to DONE.
  always_ff @(posedge clk) begin
    // NOTE: these datapath registers are not reset; they are always loaded on accept before use.
    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          s_q          <= sgn;
          e_q          <= e_init;
          mb_q         <= {1'b1, bus.b.mant};
          rem_q        <= {2'b00, 1'b1, bus.a.mant};
          q_q          <= '0;
          cnt_q        <= '0;
          spec_res_q   <= spec_res;
          spec_flags_q <= spec_flags;
        end
      end
      S_DIV: begin
        rem_q <= rem_keep << 1;
        q_q   <= {q_q[QBITS-2:0], qbit};
        cnt_q <= cnt_q + CW'(1);
      end
      default: ;
    endcase
  end

  // Result and flag registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      flags_q  <= '0;
    end else if (state_q == S_NORM) begin
      result_q <= rn_result;
      flags_q  <= rn_flags;
    end else if (state_q == S_SPEC) begin
      result_q <= spec_res_q;
      flags_q  <= spec_flags_q;
    end
  end

endmodule

// File: tb/tb_fpu_div_core.sv
// Self-checking bench for fpu_div_core: IEEE-style reference model built on
// double-precision real division, a scoreboard queue and a per-cycle monitor.
module tb_fpu_div_core;

  localparam int QBITS = 26;

  typedef struct {
    logic [31:0] r;
    logic [3:0]  f;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];

  fpu_div_core_if bif ();

  fpu_div_core #(.QBITS(QBITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference: specials from the classification rules; normal quotients from
  // double-precision division (exact enough to round once more to 24 bits),
  // then round-to-nearest-even to 24 bits and flush out-of-range exponents.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic [3:0] f,
                                output logic spec);
    logic        s;
    logic [7:0]  ea, eb;
    logic [22:0] fa, fb;
    logic        za, zb, na, nb, ia, ib;
    real         ra, rb, rq;
    logic [63:0] qb;
    int          ef;
    logic [23:0] m;
    logic [28:0] rest;
    logic        carry;
    s  = a[31] ^ b[31];
    ea = a[30:23]; eb = b[30:23];
    fa = a[22:0];  fb = b[22:0];
    za = (ea == 0); zb = (eb == 0);
    na = (ea == 8'hFF) && (fa != 0); nb = (eb == 8'hFF) && (fb != 0);
    ia = (ea == 8'hFF) && (fa == 0); ib = (eb == 8'hFF) && (fb == 0);
    spec = 1'b1;
    f = 4'b0000;
    r = 32'h0;
    if (na || nb || (za && zb) || (ia && ib)) begin
      r = 32'h7FC00000; f = 4'b1000;
    end else if (zb && !ia) begin
      r = {s, 8'hFF, 23'h0}; f = 4'b0100;
    end else if (ia) begin
      r = {s, 8'hFF, 23'h0};
    end else if (ib || za) begin
      r = {s, 31'h0};
    end else begin
      spec = 1'b0;
      ra = $bitstoreal({1'b0, (11'(ea) + 11'd896), fa, 29'h0});
      rb = $bitstoreal({1'b0, (11'(eb) + 11'd896), fb, 29'h0});
      rq = ra / rb;
      qb = $realtobits(rq);
      ef = int'({21'd0, qb[62:52]}) - 896;
      m = {1'b1, qb[51:29]};
      rest = qb[28:0];
      carry = 1'b0;
      if (rest > 29'h1000_0000 || (rest == 29'h1000_0000 && m[0]))
        {carry, m} = {1'b0, m} + 25'd1;
      if (carry) ef++;
      if (ef >= 255) begin
        r = {s, 8'hFF, 23'h0}; f = 4'b0010;
      end else if (ef <= 0) begin
        r = {s, 31'h0}; f = 4'b0001;
      end else begin
        r = {s, ef[7:0], m[22:0]};
      end
    end
  endfunction

  function automatic logic [31:0] rand_fp();
    int          sel;
    logic [7:0]  e;
    logic [22:0] m;
    sel = $urandom_range(0, 19);
    m = 23'($urandom);
    if (sel == 0) e = 8'd0;
    else if (sel == 1) begin
      e = 8'hFF;
      if ($urandom_range(0, 1) == 0) m = 23'd0;
    end else if (sel < 5) e = 8'($urandom_range(1, 20));
    else if (sel < 8) e = 8'($urandom_range(235, 254));
    else e = 8'($urandom_range(100, 154));
    if ($urandom_range(0, 7) == 0) m = 23'd0;
    return {1'($urandom), e, m};
  endfunction

  // Monitor: every cycle with a valid result is compared against the scoreboard head.
  always @(negedge clk) begin
    if (!rst) begin
      if (bif.out_valid) begin
        if (exp_q.size() == 0) begin
          check("out_valid_unexpected", 64'(bif.out_valid), 64'd0);
        end else begin
          check("result", 64'(bif.result), 64'(exp_q[0].r));
          check("flags", 64'(bif.flags), 64'(exp_q[0].f));
          if (bif.out_ready) void'(exp_q.pop_front());
        end
      end else begin
        check("flags_when_idle", 64'(bif.flags), 64'd0);
      end
    end
  end

  task automatic wait_in_ready();
    int n;
    n = 0;
    while (!bif.in_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    check("in_ready_wait", 64'(bif.in_ready), 64'd1);
  endtask

  // Present operands, accept, push the expectation; returns edges to first out_valid.
  task automatic launch(input logic [31:0] a, input logic [31:0] b, output int lat, output logic spec);
    logic [31:0] er;
    logic [3:0]  ef;
    int          n;
    model(a, b, er, ef, spec);
    wait_in_ready();
    bif.a = a; bif.b = b; bif.in_valid = 1'b1;
    @(posedge clk); #1;
    bif.in_valid = 1'b0;
    exp_q.push_back('{r: er, f: ef});
    n = 1;
    while (!bif.out_valid && n < 200) begin
      @(posedge clk); #1; n++;
    end
    lat = n;
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int hold);
    int   lat;
    logic spec;
    bif.out_ready = (hold == 0);
    launch(a, b, lat, spec);
    check("latency", 64'(lat), spec ? 64'd2 : 64'(QBITS + 2));
    repeat (hold) begin
      @(posedge clk); #1;
    end
    bif.out_ready = 1'b1;
    @(posedge clk); #1;
    check("out_valid_after_handshake", 64'(bif.out_valid), 64'd0);
  endtask

  task automatic pin_model(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] er, input logic [3:0] ef);
    logic [31:0] r;
    logic [3:0]  f;
    logic        sp;
    model(a, b, r, f, sp);
    check({name, "_model_result"}, 64'(r), 64'(er));
    check({name, "_model_flags"}, 64'(f), 64'(ef));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int          lat;
    logic        spec;
    logic [31:0] cap_r;
    logic [3:0]  cap_f;

    bif.in_valid = 1'b0;
    bif.a = 32'h0;
    bif.b = 32'h0;
    bif.out_ready = 1'b1;

    // Hand-computed anchors for the reference model.
    pin_model("six_div_two", 32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000);
    pin_model("one_third",   32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000);
    pin_model("neg_div_0",   32'hBF800000, 32'h00000000, 32'hFF800000, 4'b0100);
    pin_model("zero_zero",   32'h00000000, 32'h00000000, 32'h7FC00000, 4'b1000);
    pin_model("overflow",    32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, 4'b0010);
    pin_model("underflow",   32'h00800000, 32'h40000000, 32'h00000000, 4'b0001);
    pin_model("ten_div_5",   32'h41200000, 32'h40A00000, 32'h40000000, 4'b0000);

    // Reset state.
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_in_ready", 64'(bif.in_ready), 64'd1);
    check("reset_out_valid", 64'(bif.out_valid), 64'd0);
    check("reset_result", 64'(bif.result), 64'd0);
    check("reset_flags", 64'(bif.flags), 64'd0);

    // Directed operations.
    run_op(32'h40C00000, 32'h40000000, 0);
    run_op(32'h3F800000, 32'h40400000, 0);
    run_op(32'hBF800000, 32'h00000000, 0);
    run_op(32'h00000000, 32'h00000000, 0);
    run_op(32'h7F7FFFFF, 32'h3F000000, 0);
    run_op(32'h00800000, 32'h40000000, 0);
    run_op(32'h7F800000, 32'h40000000, 0);
    run_op(32'h40000000, 32'hFF800000, 0);

    // Backpressure: result held for 10 cycles, new operands ignored.
    bif.out_ready = 1'b0;
    launch(32'h40C00000, 32'h40000000, lat, spec);
    check("bp_latency", 64'(lat), 64'(QBITS + 2));
    cap_r = bif.result;
    cap_f = bif.flags;
    for (int i = 0; i < 10; i++) begin
      bif.in_valid = 1'b1;
      bif.a = 32'h3F800000;
      bif.b = 32'h40400000;
      @(posedge clk); #1;
      check("bp_result_stable", 64'(bif.result), 64'(cap_r));
      check("bp_flags_stable", 64'(bif.flags), 64'(cap_f));
      check("bp_in_ready_low", 64'(bif.in_ready), 64'd0);
      check("bp_out_valid_high", 64'(bif.out_valid), 64'd1);
    end
    bif.in_valid = 1'b0;
    bif.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_out_valid", 64'(bif.out_valid), 64'd0);
    check("bp_release_in_ready", 64'(bif.in_ready), 64'd1);
    run_op(32'h3F800000, 32'h40400000, 0);

    // Reset at iteration 10 of a division aborts it.
    wait_in_ready();
    bif.a = 32'h40C00000; bif.b = 32'h40000000; bif.in_valid = 1'b1;
    @(posedge clk); #1;
    bif.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_in_ready", 64'(bif.in_ready), 64'd1);
    check("abort_out_valid", 64'(bif.out_valid), 64'd0);
    run_op(32'h41200000, 32'h40A00000, 0);

    // Randomized operations with random result backpressure.
    for (int i = 0; i < 250; i++) begin
      run_op(rand_fp(), rand_fp(), int'($urandom_range(0, 2)));
    end

    repeat (2) @(posedge clk);
    #1 check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
